addsub_arbiter: RTL
===================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester n has an operation pending.
REQ-005 req0_ready, req1_ready  output  1 each  requester n's operation is accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  4 each  operands.
REQ-007 req0_mode, req1_mode  input  1 each  0 = add (a+b); 1 = subtract (a-b, two's complement).
REQ-008 rsp_valid  output  1  result registers hold a result not yet taken.
REQ-009 rsp_ready  input  1  consumer takes the result this cycle.
REQ-010 rsp_id  output  1  index of the requester that owns the result.
REQ-011 rsp_s  output  4  sum or difference.
REQ-012 rsp_cout  output  1  carry out; for subtract, 1 means no borrow.
REQ-013 rsp_ovf  output  1  signed overflow; present only under the configuration macro.

Function
REQ-014 A single shared 4-bit adder-subtractor SHALL serve both requesters; at most one operation is accepted per cycle.
REQ-015 FSM states SHALL be IDLE (no result held) and RESP (rsp_valid=1).
REQ-016 Transfer rule: reqN is accepted when reqN_valid && reqN_ready; the response is taken when rsp_valid && rsp_ready.
REQ-017 reqN_ready SHALL be 1 only for the granted requester, and only when the FSM is in IDLE or (RESP && rsp_ready).
REQ-018 Grant rule:
- When one valid is high, grant that requester.
- When both valids are high, grant the requester not granted last.
- The last-grant pointer SHALL update only on an accepted request.
REQ-019 Latency: an operation accepted in cycle N SHALL produce rsp_valid=1 with registered rsp_s, rsp_cout and rsp_id in cycle N+1.
REQ-020 Transitions:
- IDLE + accept -> RESP.
- RESP + rsp_ready + accept -> RESP, loaded with the new result (back-to-back, one result per cycle).
- RESP + rsp_ready + no accept -> IDLE.
- RESP + !rsp_ready -> RESP, all response outputs held stable.
REQ-021 Requesters SHALL hold valid and operands stable until accepted; the block SHALL NOT drop or duplicate an operation.
REQ-022 Arithmetic SHALL be 4-bit modulo 16: rsp_s = (a + (b XOR {4{mode}}) + mode) mod 16, and rsp_cout is bit 4 of that sum.

Reset
REQ-023 During rst the FSM SHALL be IDLE; rsp_valid, rsp_id, rsp_s, rsp_cout and rsp_ovf SHALL be 0; the last-grant pointer SHALL equal 1, so requester 0 wins the first tie.
REQ-024 Both ready outputs SHALL be 0 in any cycle where rst=1.
REQ-025 A reset asserted while in RESP SHALL discard the held result, with no response output.

Configuration
REQ-026 Macro ADDSUB_ARBITER_OVF_EN:
- Defined: the rsp_ovf port exists. It SHALL be registered with the result and equal (a[3] == b'[3]) && (s[3] != a[3]), where b' = b XOR {4{mode}}.
- Undefined: the port and its logic SHALL be absent.
- All other behaviour SHALL be identical in both builds.

Structure
REQ-027 Shared package addsub_pkg SHALL hold the data width (4), the mode encodings (ADD=0, SUB=1) and the FSM state encodings (IDLE, RESP).
REQ-028 The datapath SHALL be one instance of the existing adder_subtractor sub-module, fed by a 2:1 operand/mode mux driven by the grant.

Verification
REQ-029 req0 add 5+3, rsp_ready=1 -> next cycle: rsp_valid=1, rsp_id=0, rsp_s=8, rsp_cout=0; rsp_ovf=1 when the macro is defined.
REQ-030 req1 subtract 5-3 -> rsp_s=2, rsp_cout=1, rsp_id=1; then subtract 3-5 -> rsp_s=14, rsp_cout=0.
REQ-031 Both valid continuously after reset, rsp_ready=1 -> accepts alternate 0,1,0,1; one response per cycle; no gaps.
REQ-032 rsp_ready=0 for 3 cycles with both valid -> rsp_s/rsp_id held stable; both readys 0; the owed requester is then accepted the cycle rsp_ready rises.
REQ-033 rst pulsed in RESP -> next cycle rsp_valid=0; a following tie is granted to requester 0.
REQ-034 Operands 15+1 add -> rsp_s=0, rsp_cout=1; rsp_ovf=0 when the macro is defined.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared widths and encodings for the add/subtract arbiter.
// The optional overflow output is enabled by the ADDSUB_ARBITER_OVF_EN macro.
package addsub_pkg;

  localparam int WIDTH = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/adder_subtractor.sv
// Combinational WIDTH-bit adder/subtractor: s = a + (b ^ {mode}) + mode.
// Build with ADDSUB_ARBITER_OVF_EN to add the signed overflow output.
module adder_subtractor
  import addsub_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o
`ifdef ADDSUB_ARBITER_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  logic             sub;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   sum;

  assign sub = (mode_i == MODE_SUB);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_binv
    assign b_x[gi] = b_i[gi] ^ sub;
  end

  assign sum    = {1'b0, a_i} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};
  assign s_o    = sum[WIDTH-1:0];
  assign cout_o = sum[WIDTH];

`ifdef ADDSUB_ARBITER_OVF_EN
  assign ovf_o = (a_i[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
`endif

endmodule

// File: rtl/addsub_arbiter.sv
// Two requesters share one adder/subtractor; round-robin on ties, one registered result.
// ADDSUB_ARBITER_OVF_EN adds the registered rsp_ovf output.
module addsub_arbiter
  import addsub_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_mode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_cout
`ifdef ADDSUB_ARBITER_OVF_EN
  ,
  output logic             rsp_ovf
`endif
);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             grant, can_accept, accept;
  logic [WIDTH-1:0] op_a, op_b, alu_s;
  logic             op_mode, alu_cout;
  logic             rsp_id_q, rsp_cout_q;
  logic [WIDTH-1:0] rsp_s_q;

  always_comb begin
    grant = ~last_q;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
  end

  // The result register frees up in the same cycle the consumer takes it.
  assign can_accept = !rst && ((state_q == IDLE) || rsp_ready);
  assign req0_ready = can_accept && req0_valid && !grant;
  assign req1_ready = can_accept && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign op_a    = grant ? req1_a    : req0_a;
  assign op_b    = grant ? req1_b    : req0_b;
  assign op_mode = grant ? req1_mode : req0_mode;

`ifdef ADDSUB_ARBITER_OVF_EN
  logic alu_ovf, rsp_ovf_q;
`endif

  adder_subtractor u_alu (
    .a_i    (op_a),
    .b_i    (op_b),
    .mode_i (op_mode),
    .s_o    (alu_s),
    .cout_o (alu_cout)
`ifdef ADDSUB_ARBITER_OVF_EN
    ,
    .ovf_o  (alu_ovf)
`endif
  );

  always_comb begin
    state_d = state_q;
    last_d  = accept ? grant : last_q;
    case (state_q)
      IDLE:    if (accept) state_d = RESP;
      RESP:    if (rsp_ready && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      rsp_id_q   <= 1'b0;
      rsp_s_q    <= '0;
      rsp_cout_q <= 1'b0;
`ifdef ADDSUB_ARBITER_OVF_EN
      rsp_ovf_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (accept) begin
        rsp_id_q   <= grant;
        rsp_s_q    <= alu_s;
        rsp_cout_q <= alu_cout;
`ifdef ADDSUB_ARBITER_OVF_EN
        rsp_ovf_q  <= alu_ovf;
`endif
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_cout  = rsp_cout_q;
`ifdef ADDSUB_ARBITER_OVF_EN
  assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule
